sfifo_ram_pfx: RTL and testbench
================================

SFIFO_RAM_PFX -- requirements
Module: sfifo_ram_pfx

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data width in bits.
REQ-002 SHALL have parameter DEPTH_NBITS, default 12; RAM depth DEPTH = 2^DEPTH_NBITS.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 1..3, RAM read latency in cycles.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-4, almost-full threshold on count.
REQ-005 SHALL have parameter AE_LVL, default 2, almost-empty threshold on count.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-008 SHALL have port flush, input, 1, synchronous clear of all contents.
REQ-009 SHALL have port wr, input, 1, write request.
REQ-010 SHALL have port din, input, WIDTH, write data.
REQ-011 SHALL have port rd, input, 1, pop of the current head.
REQ-012 SHALL have port dout, output, WIDTH, head data, first-word fall-through.
REQ-013 SHALL have port count, output, DEPTH_NBITS+2, entries accepted and not yet popped.
REQ-014 SHALL have ports full, empty, afull, aempty, output, 1 each.
REQ-015 SHALL have ports ovf, udf, output, 1 each, sticky overflow and underflow errors.

Function
REQ-016 SHALL store data in a RAM of DEPTH words, followed by a prefetch FIFO of PF_DEPTH = RD_LAT+1 entries.
REQ-017 SHALL accept wr only when full=0; wr while full SHALL be dropped and SHALL set ovf.
REQ-018 SHALL accept rd only when empty=0; rd while empty SHALL be ignored and SHALL set udf.
REQ-019 SHALL assert full when the RAM holds DEPTH words; prefetch and in-flight entries SHALL not count toward full.
REQ-020 SHALL assert empty when the prefetch FIFO holds no entries; dout is valid whenever empty=0.
REQ-021 SHALL issue a RAM read in a cycle only if the RAM is non-empty and (in-flight reads + prefetch occupancy) < PF_DEPTH, so the prefetch FIFO never overflows.
REQ-022 SHALL track in-flight reads with an RD_LAT-stage valid shift register; a valid at the last stage SHALL write the prefetch FIFO.
REQ-023 SHALL, for wr at cycle N into an entirely empty block, drop empty at N+RD_LAT+2 with dout = din; there is no bypass path.
REQ-024 SHALL, in steady state with rd held high, sustain one pop per cycle with no bubbles.
REQ-025 SHALL handle simultaneous accepted wr and rd by leaving count unchanged; otherwise count changes by +1 or -1 per accepted operation.
REQ-026 SHALL register count, full, empty, afull, aempty, ovf and udf; afull = (count >= AF_LVL), aempty = (count <= AE_LVL).
REQ-027 SHALL wrap RAM pointers modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-028 SHALL, on flush=1, in the next cycle clear pointers, the in-flight valid pipe, the prefetch FIFO, count, ovf and udf, and discard RAM data returning later.
REQ-029 SHALL give flush priority over wr and rd in the same cycle; neither is accepted and no error is flagged.

Reset
REQ-030 SHALL, while rstn=0 at a clk edge, set count=0, empty=1, aempty=1, full=0, afull=0, ovf=0, udf=0, and clear the valid pipe and pointers.
REQ-031 SHALL not reset RAM contents; dout is don't-care while empty=1.
REQ-032 SHALL, on reset mid-operation, discard in-flight reads so that no stale write to the prefetch FIFO occurs after release.

Structure
REQ-033 SHALL take reset and clock-edge macros from the shared defines.vh include; RD_LAT limits and PF_DEPTH derivation SHALL live in a shared constants include.
REQ-034 SHALL instantiate one sub-module, ram_2p_lat (simple dual-port RAM, RD_LAT registered read stages); all control SHALL stay in sfifo_ram_pfx.

Verification
REQ-035 SHALL cover: RD_LAT=1, reset, wr 0xA5 at cycle 0 -> empty falls at cycle 3, dout=0xA5, count=1.
REQ-036 SHALL cover: RD_LAT=3, 20 back-to-back writes then rd held high -> 20 pops on consecutive cycles, in order, no bubbles.
REQ-037 SHALL cover: DEPTH_NBITS=3, fill until full=1, then one extra wr -> data dropped, ovf=1, count unchanged.
REQ-038 SHALL cover: rd while empty=1 -> udf=1, count=0; a following flush -> udf=0.
REQ-039 SHALL cover: flush asserted with 2 reads in flight and wr=1 in the same cycle -> next cycle empty=1, count=0, and no entry appears afterwards.
REQ-040 SHALL cover: random wr/rd for 10k cycles against a reference queue -> data order, count, afull and aempty match every cycle.

Source files
------------

// File: rtl/sfifo_ram_pfx_pkg.sv
// Shared constants and types for the RAM-backed FIFO with a prefetch buffer.
// The prefetch depth is derived from the RAM read latency here so every user agrees on it.
package sfifo_ram_pfx_pkg;

   localparam int RD_LAT_MAX = 3;
   // Wide enough for the in-flight + prefetch sum, which tops out at 2*RD_LAT_MAX+1.
   localparam int PF_CNT_W   = $clog2(2 * RD_LAT_MAX + 2);

   function automatic int f_pf_depth(input int rd_lat);
      return rd_lat + 1;
   endfunction

   typedef struct packed {
      logic wr_acc;
      logic rd_acc;
      logic issue;
      logic land;
   } op_t;

endpackage

// File: rtl/sfifo_ram_pfx_if.sv
// Push/pop and status bundle of the FIFO; the slave side is the FIFO itself.
interface sfifo_ram_pfx_if #(
   parameter int WIDTH       = 12,
   parameter int DEPTH_NBITS = 12
);
   logic                   flush;
   logic                   wr;
   logic [WIDTH-1:0]       din;
   logic                   rd;
   logic [WIDTH-1:0]       dout;
   logic [DEPTH_NBITS+1:0] count;
   logic                   full;
   logic                   empty;
   logic                   afull;
   logic                   aempty;
   logic                   ovf;
   logic                   udf;

   modport master (
      output flush, wr, din, rd,
      input  dout, count, full, empty, afull, aempty, ovf, udf
   );

   modport slave (
      input  flush, wr, din, rd,
      output dout, count, full, empty, afull, aempty, ovf, udf
   );
endinterface

// File: rtl/ram_2p_lat.sv
// Simple dual-port RAM with RD_LAT registered read stages; contents are never reset.
module ram_2p_lat #(
   parameter int WIDTH  = 12,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] r_mem  [DEPTH];
   logic [WIDTH-1:0] r_pipe [RD_LAT];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_pipe[0] <= r_mem[i_raddr];
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
   end

   assign o_rdata = r_pipe[RD_LAT-1];
endmodule

// File: rtl/sfifo_ram_pfx.sv
// Synchronous FIFO: RAM main store feeding a small first-word-fall-through prefetch FIFO.
// All pointer, in-flight and status control lives here; the RAM only stores and delays data.
module sfifo_ram_pfx
   import sfifo_ram_pfx_pkg::*;
#(
   parameter int WIDTH       = 12,
   parameter int DEPTH_NBITS = 12,
   parameter int RD_LAT      = 1,
   parameter int AF_LVL      = (1 << DEPTH_NBITS) - 4,
   parameter int AE_LVL      = 2
) (
   input  logic clk,
   input  logic rstn,
   sfifo_ram_pfx_if.slave bus
);
   localparam int PF_DEPTH = f_pf_depth(RD_LAT);
   localparam int PF_IW    = $clog2(PF_DEPTH);
   localparam int PW       = DEPTH_NBITS + 1;
   localparam int CW       = DEPTH_NBITS + 2;
   localparam logic [PF_IW-1:0] PF_LAST = PF_IW'(PF_DEPTH - 1);

   logic [PW-1:0]       r_wptr, r_rptr;
   logic [RD_LAT-1:0]   r_vld;
   logic [WIDTH-1:0]    r_pf_mem [PF_DEPTH];
   logic [PF_IW-1:0]    r_pf_wi, r_pf_ri;
   logic [PF_CNT_W-1:0] r_pf_cnt;
   logic [CW-1:0]       r_count;
   logic                r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;

   op_t                 w_op;
   logic                w_ram_empty;
   logic [PF_CNT_W-1:0] w_infl;
   logic [PF_CNT_W-1:0] w_pf_cnt_nxt;
   logic [PW-1:0]       w_wptr_nxt, w_rptr_nxt;
   logic [CW-1:0]       w_count_nxt;
   logic [WIDTH-1:0]    w_rdata;

   always_comb begin
      w_ram_empty = (r_wptr == r_rptr);
      w_infl      = '0;
      for (int i = 0; i < RD_LAT; i++) w_infl = w_infl + PF_CNT_W'(r_vld[i]);
      w_op.wr_acc = bus.wr & ~r_full & ~bus.flush;
      w_op.rd_acc = bus.rd & ~r_empty & ~bus.flush;
      w_op.land   = r_vld[RD_LAT-1];
      // A pop this cycle frees a slot, which keeps rd-held-high streaming bubble-free.
      w_op.issue  = ~bus.flush & ~w_ram_empty &
                    ((w_infl + r_pf_cnt - PF_CNT_W'(w_op.rd_acc)) < PF_CNT_W'(PF_DEPTH));
      w_wptr_nxt   = r_wptr + PW'(w_op.wr_acc);
      w_rptr_nxt   = r_rptr + PW'(w_op.issue);
      w_pf_cnt_nxt = r_pf_cnt + PF_CNT_W'(w_op.land) - PF_CNT_W'(w_op.rd_acc);
      w_count_nxt  = r_count + CW'(w_op.wr_acc) - CW'(w_op.rd_acc);
   end

   ram_2p_lat #(
      .WIDTH  (WIDTH),
      .ADDR_W (DEPTH_NBITS),
      .RD_LAT (RD_LAT)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_op.wr_acc),
      .i_waddr (r_wptr[DEPTH_NBITS-1:0]),
      .i_wdata (bus.din),
      .i_re    (w_op.issue),
      .i_raddr (r_rptr[DEPTH_NBITS-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (w_op.land) r_pf_mem[r_pf_wi] <= w_rdata;
   end

   // Flush and reset clear the same state; clearing r_vld drops any RAM data still in the pipe.
   always_ff @(posedge clk) begin
      if (!rstn || bus.flush) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_vld    <= '0;
         r_pf_wi  <= '0;
         r_pf_ri  <= '0;
         r_pf_cnt <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wptr   <= w_wptr_nxt;
         r_rptr   <= w_rptr_nxt;
         r_vld    <= RD_LAT'({r_vld, w_op.issue});
         if (w_op.land)   r_pf_wi <= (r_pf_wi == PF_LAST) ? '0 : r_pf_wi + PF_IW'(1);
         if (w_op.rd_acc) r_pf_ri <= (r_pf_ri == PF_LAST) ? '0 : r_pf_ri + PF_IW'(1);
         r_pf_cnt <= w_pf_cnt_nxt;
         r_count  <= w_count_nxt;
         r_full   <= (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                     (w_wptr_nxt[PW-2:0] == w_rptr_nxt[PW-2:0]);
         r_empty  <= (w_pf_cnt_nxt == '0);
         r_afull  <= (w_count_nxt >= CW'(AF_LVL));
         r_aempty <= (w_count_nxt <= CW'(AE_LVL));
         r_ovf    <= r_ovf | (bus.wr & r_full);
         r_udf    <= r_udf | (bus.rd & r_empty);
      end
   end

   assign bus.dout   = r_pf_mem[r_pf_ri];
   assign bus.count  = r_count;
   assign bus.full   = r_full;
   assign bus.empty  = r_empty;
   assign bus.afull  = r_afull;
   assign bus.aempty = r_aempty;
   assign bus.ovf    = r_ovf;
   assign bus.udf    = r_udf;
endmodule

// File: tb/tb_sfifo_ram_pfx.sv
// Bench for sfifo_ram_pfx: two instances (RD_LAT=1/DEPTH=8 and RD_LAT=3/DEPTH=32) share one
// stimulus stream; a queue model of each is compared every cycle, plus directed literal checks.
module tb_sfifo_ram_pfx;

   typedef struct {
      logic [11:0] d;
      int          st;   // 0: in RAM, >0: read cycles still to go, -1: visible in prefetch
   } ent_t;
   typedef ent_t ent_q_t[$];

   logic        clk;
   logic        rstn;
   logic        flush, wr, rd;
   logic [11:0] din;

   int n_cmp = 0;
   int n_bad = 0;

   ent_q_t mq_a, mq_b;
   bit     ovf_a, udf_a, ovf_b, udf_b;

   sfifo_ram_pfx_if #(.WIDTH(12), .DEPTH_NBITS(3)) if_a ();
   sfifo_ram_pfx_if #(.WIDTH(12), .DEPTH_NBITS(5)) if_b ();

   assign if_a.flush = flush;
   assign if_a.wr    = wr;
   assign if_a.din   = din;
   assign if_a.rd    = rd;
   assign if_b.flush = flush;
   assign if_b.wr    = wr;
   assign if_b.din   = din;
   assign if_b.rd    = rd;

   sfifo_ram_pfx #(.WIDTH(12), .DEPTH_NBITS(3), .RD_LAT(1)) u_dut_a (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_a)
   );

   sfifo_ram_pfx #(.WIDTH(12), .DEPTH_NBITS(5), .RD_LAT(3)) u_dut_b (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic drv(input bit f, input bit w, input logic [11:0] d, input bit r);
      flush = f;
      wr    = w;
      din   = d;
      rd    = r;
   endtask

   // One clock edge of the FIFO as seen from outside: entries move RAM -> read pipe -> prefetch.
   task automatic model_step(inout ent_q_t q, inout bit m_ovf, inout bit m_udf,
                             input int depth, input int lat,
                             input bit f, input bit w, input logic [11:0] dat, input bit r);
      int n_ram = 0;
      int n_fly = 0;
      int n_pf  = 0;
      bit wa, ra, iss;
      if (f) begin
         q.delete();
         m_ovf = 0;
         m_udf = 0;
         return;
      end
      foreach (q[i]) begin
         if (q[i].st == 0)     n_ram++;
         else if (q[i].st > 0) n_fly++;
         else                  n_pf++;
      end
      wa = w && (n_ram < depth);
      ra = r && (n_pf > 0);
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_udf = 1;
      iss = (n_ram > 0) && ((n_fly + n_pf - int'(ra)) < lat + 1);
      if (ra) q.delete(0);
      foreach (q[i]) begin
         if (q[i].st > 0) begin
            q[i].st--;
            if (q[i].st == 0) q[i].st = -1;
         end
      end
      if (iss) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].st == 0) begin
               q[i].st = lat;
               break;
            end
         end
      end
      if (wa) q.push_back('{d: dat, st: 0});
   endtask

   task automatic check_model(input string nm, input ent_q_t q, input bit m_ovf, input bit m_udf,
                              input int depth, input int af, input int ae,
                              input logic [31:0] cnt, input logic e, input logic f,
                              input logic a_f, input logic a_e, input logic o, input logic u,
                              input logic [11:0] dq);
      int n_ram = 0;
      int n_pf  = 0;
      foreach (q[i]) begin
         if (q[i].st == 0)      n_ram++;
         else if (q[i].st < 0)  n_pf++;
      end
      chk({nm, ".count"},  cnt, q.size());
      chk({nm, ".empty"},  e,   n_pf == 0);
      chk({nm, ".full"},   f,   n_ram == depth);
      chk({nm, ".afull"},  a_f, q.size() >= af);
      chk({nm, ".aempty"}, a_e, q.size() <= ae);
      chk({nm, ".ovf"},    o,   m_ovf);
      chk({nm, ".udf"},    u,   m_udf);
      if (n_pf > 0) chk({nm, ".dout"}, dq, q[0].d);
   endtask

   // Model advances on the same edge as the DUTs, from the inputs driven at the prior negedge.
   initial begin
      forever begin
         @(posedge clk);
         if (!rstn) begin
            mq_a.delete(); ovf_a = 0; udf_a = 0;
            mq_b.delete(); ovf_b = 0; udf_b = 0;
         end else begin
            model_step(mq_a, ovf_a, udf_a, 8,  1, flush, wr, din, rd);
            model_step(mq_b, ovf_b, udf_b, 32, 3, flush, wr, din, rd);
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_model("A", mq_a, ovf_a, udf_a, 8, 4, 2, 32'(if_a.count), if_a.empty, if_a.full,
                     if_a.afull, if_a.aempty, if_a.ovf, if_a.udf, if_a.dout);
         check_model("B", mq_b, ovf_b, udf_b, 32, 28, 2, 32'(if_b.count), if_b.empty, if_b.full,
                     if_b.afull, if_b.aempty, if_b.ovf, if_b.udf, if_b.dout);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bias;
      rstn = 1'b0;
      drv(0, 0, 12'h000, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      chk("rst.count",  32'(if_a.count), 0);
      chk("rst.empty",  if_a.empty,  1);
      chk("rst.aempty", if_a.aempty, 1);
      chk("rst.full",   if_a.full,   0);
      chk("rst.afull",  if_a.afull,  0);
      chk("rst.ovf",    if_a.ovf,    0);
      chk("rst.udf",    if_a.udf,    0);
      chk("rst.b_empty", if_b.empty, 1);

      // Single write into an empty block: empty falls RD_LAT+2 cycles later.
      drv(0, 1, 12'h0A5, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("lat.a_c1_empty", if_a.empty, 1);
      chk("lat.a_c1_count", 32'(if_a.count), 1);
      @(negedge clk);
      chk("lat.a_c2_empty", if_a.empty, 1);
      @(negedge clk);
      chk("lat.a_c3_empty", if_a.empty, 0);
      chk("lat.a_c3_dout",  if_a.dout, 12'h0A5);
      chk("lat.a_c3_count", 32'(if_a.count), 1);
      chk("lat.b_c3_empty", if_b.empty, 1);
      @(negedge clk);
      chk("lat.b_c4_empty", if_b.empty, 1);
      @(negedge clk);
      chk("lat.b_c5_empty", if_b.empty, 0);
      chk("lat.b_c5_dout",  if_b.dout, 12'h0A5);
      drv(1, 0, 12'h000, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);

      // 20 back-to-back writes, then rd held high: one pop per cycle on the RD_LAT=3 instance.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); drv(0, 1, 12'h100 + 12'(i), 0);
      end
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("stream.b_count", 32'(if_b.count), 20);
      for (int k = 0; k < 20; k++) begin
         chk("stream.b_empty", if_b.empty, 0);
         chk("stream.b_dout",  if_b.dout, 12'h100 + 12'(k));
         drv(0, 0, 12'h000, 1);
         @(negedge clk);
      end
      drv(0, 0, 12'h000, 0);
      chk("stream.b_drained", if_b.empty, 1);
      drv(1, 0, 12'h000, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);

      // Fill the 8-deep instance: RAM full plus two prefetched words gives count 10.
      n = 0;
      @(negedge clk);
      while (if_a.full !== 1'b1 && n < 40) begin
         drv(0, 1, 12'h200 + 12'(n), 0);
         @(negedge clk);
         n++;
      end
      drv(0, 0, 12'h000, 0);
      chk("fill.a_full",  if_a.full, 1);
      chk("fill.a_count", 32'(if_a.count), 10);
      chk("fill.a_ovf0",  if_a.ovf, 0);
      drv(0, 1, 12'h2FF, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("ovf.a_ovf",   if_a.ovf, 1);
      chk("ovf.a_count", 32'(if_a.count), 10);
      chk("ovf.a_full",  if_a.full, 1);
      for (int k = 0; k < 10; k++) begin
         chk("ovf.a_dout", if_a.dout, 12'h200 + 12'(k));
         drv(0, 0, 12'h000, 1);
         @(negedge clk);
      end
      drv(0, 0, 12'h000, 0);
      chk("ovf.a_drained", if_a.empty, 1);
      drv(1, 0, 12'h000, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);

      // Underflow is sticky until flush.
      @(negedge clk); drv(0, 0, 12'h000, 1);
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("udf.a_udf",   if_a.udf, 1);
      chk("udf.a_count", 32'(if_a.count), 0);
      drv(1, 0, 12'h000, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("udf.a_clear", if_a.udf, 0);

      // Flush with two reads in flight on the RD_LAT=3 instance and a write in the same cycle.
      @(negedge clk); drv(0, 1, 12'h301, 0);
      @(negedge clk); drv(0, 1, 12'h302, 0);
      @(negedge clk); drv(0, 1, 12'h303, 0);
      @(negedge clk); drv(1, 1, 12'h3EE, 0);
      @(negedge clk); drv(0, 0, 12'h000, 0);
      chk("flush.b_empty", if_b.empty, 1);
      chk("flush.b_count", 32'(if_b.count), 0);
      chk("flush.a_empty", if_a.empty, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("flush.b_stay_empty", if_b.empty, 1);
         chk("flush.b_stay_count", 32'(if_b.count), 0);
      end

      // Random traffic in alternating write-heavy and read-heavy phases.
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         bias = ((c / 64) % 2 == 0) ? 75 : 25;
         drv($urandom_range(0, 999) == 0, $urandom_range(0, 99) < bias,
             12'($urandom), $urandom_range(0, 99) < (100 - bias));
      end
      @(negedge clk); drv(0, 0, 12'h000, 0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
